dmem_access_unit: RTL
=====================

# dmem_access_unit

- Load/store initiator between the pipeline's memory stage and `Data_Memory`, driving its `address`, `write_enable`, `read_enable` and `write_data` inputs, and capturing `read_data`.
- Turns byte-addressed pipeline requests into word-indexed memory cycles and absorbs the memory's registered one-cycle read latency.
- Performs alignment checks, plus sub-word extraction and read-modify-write merges when `DMEM_SUBWORD_EN` is defined.
- Returns exactly one response per accepted request.

## Interface
Parameters:
- `ADDR_W`, default 32: width of the pipeline byte address and the memory address port.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: rising-edge clock shared with `Data_Memory`.
  - `rst` in 1: synchronous, active-high reset.
- Request side:
  - `req_valid` in 1: request present.
  - `req_ready` out 1: unit can accept a request.
  - `req_write` in 1: 1 = store, 0 = load.
  - `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
  - `req_signed` in 1: sign-extend sub-word loads.
  - `req_addr` in ADDR_W: byte address.
  - `req_wdata` in 32: store data, right-justified.
- Response side:
  - `resp_valid` out 1: one-cycle response pulse.
  - `resp_rdata` out 32: load result; 0 for stores and errors.
  - `resp_error` out 1: request rejected, no memory access made.
- Memory side:
  - `mem_address` out ADDR_W: word index, equal to `req_addr >> 2`.
  - `mem_write_enable` out 1: connects to `write_enable`.
  - `mem_read_enable` out 1: connects to `read_enable`.
  - `mem_write_data` out 32: connects to `write_data`.
  - `mem_read_data` in 32: connects to `read_data`; valid the cycle after a read edge.

## Operation
- States:
  - IDLE
  - RD: `mem_read_enable`=1
  - RDW: `mem_read_data` valid
  - WR: `mem_write_enable`=1
  - RSP: `resp_valid`=1
- `req_ready` = (state==IDLE); it is combinational from state and is 0 while `rst` is high.
- Handshake:
  - A request is accepted on an edge where `req_valid && req_ready`.
  - Request fields are sampled only at acceptance and held internally; the pipeline may change them afterwards.
  - There is no response backpressure; the consumer must take `resp_valid` when it pulses.
- Alignment: a request is rejected if any of the following holds:
  - half with `addr[0]`=1
  - word with `addr[1:0]`≠0
  - `req_size`=11

  On rejection: IDLE→RSP with `resp_error`=1 and no memory enable asserted.
- Transitions for legal requests:
  - Word load: IDLE→RD→RDW→RSP→IDLE.
  - Word store: IDLE→WR→RSP→IDLE.
  - Sub-word store: IDLE→RD→RDW→WR→RSP→IDLE. In RDW the read word is merged with the store data, and that merged word is written in WR.
- Byte lanes are little-endian:
  - A byte uses bits [8k+7:8k], where k=`addr[1:0]`.
  - A half uses bits [16h+15:16h], where h=`addr[1]`.
- Sub-word loads are zero-extended, or sign-extended when `req_signed`=1.
- `mem_address`, `mem_write_data` and both enables are registered. Both enables are never high in the same cycle, which keeps the unit independent of the memory's same-edge ordering.
- Reset values:
  - `resp_valid` = 0
  - `resp_rdata` = 0
  - `resp_error` = 0
  - `mem_address` = 0
  - `mem_write_data` = 0
  - `mem_write_enable` = 0
  - `mem_read_enable` = 0
  - state = IDLE
- Reset mid-operation: the request is abandoned and no response is produced. If `rst` and WR coincide on an edge, the memory still samples `mem_write_enable`=1, so that write lands. A reset in RD or RDW leaves memory unchanged.

## Timing
Cycle 0 is the acceptance cycle; outputs change on the following edges.
- Load:
  - cycle 1 RD: `mem_read_enable`=1
  - cycle 2 RDW: data captured
  - cycle 3 RSP: `resp_valid`=1
  - Latency is 3; the next acceptance is possible in cycle 4.
- Word store:
  - cycle 1 WR
  - cycle 2 RSP
- Sub-word store:
  - cycle 1 RD
  - cycle 2 RDW
  - cycle 3 WR
  - cycle 4 RSP
- Error: cycle 1 RSP.
- Throughput: one request outstanding at a time. Back-to-back requests are accepted in the cycle after RSP at the earliest.
- `resp_rdata` and `resp_error` are valid only while `resp_valid`=1; they return to 0 in the cycle after RSP.

## Configuration
- `DMEM_SUBWORD_EN` defined:
  - Byte and half accesses are supported.
  - Sub-word stores use the RD/RDW/WR read-modify-write path.
  - `req_signed` is honoured.
- `DMEM_SUBWORD_EN` not defined:
  - Only word accesses are legal.
  - Any `req_size`≠10 is rejected with `resp_error`=1.
  - `req_signed` is ignored.
  - States RD/RDW are used only by loads, and the merge logic is not built.

## Test plan
- Word store then load: store 0xDEADBEEF to addr 0x40 (`mem_address`=0x10), then load 0x40 → `resp_valid` in cycle 3 after acceptance with `resp_rdata`=0xDEADBEEF, `resp_error`=0.
- Sub-word RMW (`DMEM_SUBWORD_EN`): word 0x11223344 is at 0x80; store byte 0xAA to 0x81 → memory word becomes 0x1122AA44 and `resp_valid` appears in cycle 4. A signed byte load from 0x81 then returns 0xFFFFFFAA; unsigned returns 0x000000AA.
- Misaligned: word load at 0x42 → `resp_valid`=1, `resp_error`=1 in cycle 1, with neither memory enable ever asserted. Without the macro, a byte load to 0x40 gives the same result.
- Handshake: `req_valid` is held high with changing `req_addr` during a load → `req_ready`=0 until after RSP, and only the accepted address appears on `mem_address`.
- Reset mid-op:
  - `rst` in RDW of a sub-word store → no WR and no `resp_valid`; memory is unchanged and all outputs are 0 after the edge.
  - `rst` during WR → the write lands.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// Request/response/memory bundle between the pipeline memory stage, the
// dmem_access_unit and Data_Memory.
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32
);
    // Valid/ready: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; the response side has no backpressure and
    // resp_valid is a single-cycle pulse.
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_enable, mem_read_enable, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_enable, mem_read_enable, mem_write_data
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store initiator for Data_Memory: word indexing, alignment checks and
// read-latency absorption; byte/half access with RMW stores under DMEM_SUBWORD_EN.
module dmem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_access_unit_if.slave    bus,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDW  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t state;
    logic   accept;
    logic   bad;

`ifdef DMEM_SUBWORD_EN
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
    endfunction

    // Little-endian lane select followed by zero or sign extension.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sgn, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction
`else
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        return (sz != 2'b10) || (a != 2'b00);
    endfunction
`endif

    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bad           = misaligned(bus.req_size, bus.req_addr[1:0]);
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            bus.resp_valid       <= 1'b0;
            bus.resp_rdata       <= '0;
            bus.resp_error       <= 1'b0;
            bus.mem_address      <= '0;
            bus.mem_write_data   <= '0;
            bus.mem_write_enable <= 1'b0;
            bus.mem_read_enable  <= 1'b0;
`ifdef DMEM_SUBWORD_EN
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_off    <= 2'b00;
            r_wdata  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef DMEM_SUBWORD_EN
                        r_write  <= bus.req_write;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_off    <= bus.req_addr[1:0];
                        r_wdata  <= bus.req_wdata;
`endif
                        if (bad) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                            state          <= RSP;
                        end else begin
                            bus.mem_address <= bus.req_addr >> 2;
                            // Only full-word stores skip the read; sub-word stores read first to merge.
                            if (bus.req_write && bus.req_size == 2'b10) begin
                                bus.mem_write_data   <= bus.req_wdata;
                                bus.mem_write_enable <= 1'b1;
                                state                <= WR;
                            end else begin
                                bus.mem_read_enable <= 1'b1;
                                state               <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    bus.mem_read_enable <= 1'b0;
                    state               <= RDW;
                end
                RDW: begin
`ifdef DMEM_SUBWORD_EN
                    if (r_write) begin
                        bus.mem_write_data   <= merge(bus.mem_read_data, r_wdata, r_size, r_off);
                        bus.mem_write_enable <= 1'b1;
                        state                <= WR;
                    end else begin
                        bus.resp_rdata <= extract(bus.mem_read_data, r_size, r_signed, r_off);
                        bus.resp_valid <= 1'b1;
                        state          <= RSP;
                    end
`else
                    bus.resp_rdata <= bus.mem_read_data;
                    bus.resp_valid <= 1'b1;
                    state          <= RSP;
`endif
                end
                WR: begin
                    bus.mem_write_enable <= 1'b0;
                    bus.resp_valid       <= 1'b1;
                    state                <= RSP;
                end
                RSP: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.resp_error <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
